// File: rtl/ddsm_demod.sv
// ----------------------------------------------------------------------------
// ddsm_demod
//   Decoder end of the SP-MASH DDSM chain. Sums the modulator output stream
//   over a window of 2^WIN_LOG2 valid samples and presents the signed sum.
//   With WIN_LOG2 equal to the modulator WIDTH, the sum of a 1-bit EFM carry
//   stream started from zero state reproduces the programmed fractional word
//   exactly. This makes the block usable as a bit-exact modulator self-check.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start_i    in   one-cycle pulse: clear accumulator and open a window
//   y_i        in   signed modulator sample, OUT_W bits
//   y_vld_i    in   y_i valid this cycle
//   avg_o      out  signed window sum, ACC_W bits, registered
//   avg_vld_o  out  avg_o valid, held until accepted
//   avg_rdy_i  in   consumer ready
//   busy_o     out  window in progress (state ACCUM)
//   ovf_o      out  sticky: a valid sample was dropped, or a pending result
//                   was overwritten (continuous mode)
//
// Handshake: avg_o/avg_vld_o form a valid/ready source. A result transfers on
//   a rising edge where avg_vld_o and avg_rdy_i are both 1. avg_vld_o never
//   depends on avg_rdy_i, and avg_o is stable while avg_vld_o is 1.
//
// Build option
//   DDSM_DEMOD_CONT_EN  when defined, the block re-opens a new window right
//                       after each completion (continuous mode). A result
//                       still pending when the next window completes is
//                       overwritten, and ovf_o is set.
//                       When undefined, the block runs one window per start.
// ----------------------------------------------------------------------------
module ddsm_demod #(
  parameter int OUT_W    = 4,
  parameter int WIN_LOG2 = 9,
  parameter int ACC_W    = OUT_W + WIN_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [OUT_W-1:0] y_i,
  input  logic             y_vld_i,
  output logic [ACC_W-1:0] avg_o,
  output logic             avg_vld_o,
  input  logic             avg_rdy_i,
  output logic             busy_o,
  output logic             ovf_o
);

  // The sum of 2^WIN_LOG2 samples of OUT_W bits needs OUT_W+WIN_LOG2 bits.
  generate
    if (ACC_W < OUT_W + WIN_LOG2) begin : g_acc_w_check
      $error("ddsm_demod: ACC_W must be >= OUT_W + WIN_LOG2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [ACC_W-1:0]    r_avg;
  logic                r_avg_vld;
  logic                r_ovf;

  logic [ACC_W-1:0]    w_y_ext;
  logic [ACC_W-1:0]    w_sum;

  assign w_y_ext = {{(ACC_W-OUT_W){y_i[OUT_W-1]}}, y_i};
  // Includes the current sample, so the window's last sample goes straight
  // into the result without an extra cycle.
  assign w_sum   = r_acc + w_y_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // The sample that arrives with start_i is not counted.
          if (start_i) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ACCUM;
          end
        end

        ACCUM: begin
`ifdef DDSM_DEMOD_CONT_EN
          // In continuous mode, results drain while the next window runs.
          if (r_avg_vld && avg_rdy_i) begin
            r_avg_vld <= 1'b0;
          end
`endif
          if (start_i) begin
            // Restart: discard the partial sum and emit no result.
            r_acc <= '0;
            r_cnt <= '0;
          end else if (y_vld_i) begin
            r_cnt <= r_cnt + 1'b1;  // wraps to 0 exactly at window end
            if (r_cnt == CNT_LAST) begin
              r_avg     <= w_sum;
              r_avg_vld <= 1'b1;
`ifdef DDSM_DEMOD_CONT_EN
              r_acc <= '0;
              if (r_avg_vld && !avg_rdy_i) begin
                r_ovf <= 1'b1;
              end
`else
              r_state <= DONE;
`endif
            end else begin
              r_acc <= w_sum;
            end
          end
        end

        DONE: begin
          // start_i is ignored here, even when it arrives with avg_rdy_i.
          if (y_vld_i) begin
            r_ovf <= 1'b1;
          end
          if (avg_rdy_i) begin
            r_avg_vld <= 1'b0;
            r_state   <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign avg_o     = r_avg;
  assign avg_vld_o = r_avg_vld;
  assign busy_o    = (r_state == ACCUM);
  assign ovf_o     = r_ovf;

endmodule
